// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: opcode encodings carried on the D->E register,
// operation latencies, and the FSM state type. Both the decoder and
// mul_div_unit import this package.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8
  } mdu_op_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit.
//   startE : E-stage MDU opcode (mdu_op_e encoding)
//   HLSelE : read select, 1 = HI, 0 = LO
//   A, B   : forwarded rs / rt operands
//   Req    : exception/interrupt flush request
//   busy   : an operation is in flight
//   HLOut  : HI or LO as selected by HLSelE
// master = pipeline side, slave = mul_div_unit.
interface mul_div_unit_if;
  logic [3:0]  startE;
  logic        HLSelE;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        busy;
  logic [31:0] HLOut;

  modport master (
    output startE, HLSelE, A, B, Req,
    input  busy, HLOut
  );

  modport slave (
    input  startE, HLSelE, A, B, Req,
    output busy, HLOut
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The full result is computed at launch into a 64-bit temp register and
// committed to HI/LO on the edge that drops busy (5 cycles for mult/madd,
// 10 for div). mthi/mtlo write immediately with no busy cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mul_div_unit_if.slave (startE, HLSelE, A, B, Req, busy, HLOut)
// Build option: define MDU_MADD_EN to enable madd/maddu (opcodes 7/8);
// otherwise those opcodes behave as none.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [63:0] temp;
  logic [31:0] hi, lo;
  logic        busy_q;

  logic [31:0] a, b;
  assign a = bus.A;
  assign b = bus.B;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Division guarded against B=0 and the single signed overflow case
  // (INT_MIN / -1), which yields quotient INT_MIN, remainder 0.
  logic signed [31:0] sa, sb, sq, sr;
  logic        [31:0] uq, ur;
  assign sa = a;
  assign sb = b;

  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (b != '0) begin
      uq = a / b;
      ur = a % b;
      if (a == 32'h8000_0000 && b == '1) begin
        sq = sa;
        sr = '0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
      end
    end
  end

  logic        launch;
  logic        op_mthi, op_mtlo;
  logic [3:0]  n_cycles;
  logic [63:0] result;

  assign launch = (bus.startE != MDU_NONE) && !bus.Req && !busy_q;

  always_comb begin
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    n_cycles = '0;
    result   = '0;
    case (bus.startE)
      MDU_MULT:  begin n_cycles = MULT_CYCLES; result = prod_s; end
      MDU_MULTU: begin n_cycles = MULT_CYCLES; result = prod_u; end
      // Divide by zero re-commits the current HI/LO, leaving them unchanged.
      MDU_DIV:   begin
        n_cycles = DIV_CYCLES;
        result   = (b == '0) ? {hi, lo} : {sr, sq};
      end
      MDU_DIVU:  begin
        n_cycles = DIV_CYCLES;
        result   = (b == '0) ? {hi, lo} : {ur, uq};
      end
      MDU_MTHI:  op_mthi = 1'b1;
      MDU_MTLO:  op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin n_cycles = MULT_CYCLES; result = {hi, lo} + prod_s; end
      MDU_MADDU: begin n_cycles = MULT_CYCLES; result = {hi, lo} + prod_u; end
`else
      MDU_MADD, MDU_MADDU: ;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      temp   <= '0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            if (op_mthi) hi <= a;
            if (op_mtlo) lo <= a;
            if (n_cycles != '0) begin
              temp   <= result;
              cnt    <= n_cycles;
              state  <= S_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi     <= temp[63:32];
            lo     <= temp[31:0];
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.HLOut = bus.HLSelE ? hi : lo;

endmodule
